// File: rtl/dispatch_sequencer.sv
// Single-entry dispatch buffer with a 16-bit matrix scoreboard and a RUN/DRAIN/HALTED sequencer.
// Optional stall counter output is enabled with `define STALL_CNT_EN.

module dispatch_sequencer_chk (
  input logic        CLK,
  input logic        nRST,
  input logic [15:0] set_vec,
  input logic [15:0] clr_vec
);

  // A scoreboard bit must never be set and cleared in the same cycle.
  always @(posedge CLK) begin
    if (nRST) begin
      assert ((set_vec & clr_vec) == 16'h0000);
    end
  end

endmodule

module dispatch_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [1:0]  dec_fu_t,
  input  logic        dec_halt,
  input  logic        dec_m_reg_write,
  input  logic [3:0]  dec_matrix_rd,
  input  logic [15:0] dec_m_src,
  input  logic        s_fu_ready,
  input  logic        m_fu_ready,
  input  logic        g_fu_ready,
  output logic        s_issue,
  output logic        m_issue,
  output logic        g_issue,
  output logic [3:0]  iss_matrix_rd,
  input  logic        m_wb_valid,
  input  logic [3:0]  m_wb_rd,
  input  logic        g_wb_valid,
  input  logic [3:0]  g_wb_rd,
  output logic [15:0] pending,
  output logic        halted
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  state_r;
  logic        buf_valid_r;
  logic [1:0]  buf_fu_t_r;
  logic        buf_halt_r;
  logic        buf_m_reg_write_r;
  logic [3:0]  buf_rd_r;
  logic [15:0] buf_m_src_r;
  logic [15:0] pending_r;

  logic        hazard_s;
  logic        issue_fire_s;
  logic        discard_s;
  logic        halt_take_s;
  logic [15:0] set_vec_s;
  logic [15:0] clr_vec_s;
  logic [15:0] pending_nxt_s;

  // Issue decision, handshake and scoreboard next-state from registered state only.
  always_comb begin
    hazard_s      = (|(buf_m_src_r & pending_r)) || (buf_m_reg_write_r && pending_r[buf_rd_r]);
    s_issue       = 1'b0;
    m_issue       = 1'b0;
    g_issue       = 1'b0;
    discard_s     = 1'b0;
    halt_take_s   = 1'b0;
    if (nRST && (state_r == ST_RUN) && buf_valid_r) begin
      if (buf_halt_r) begin
        halt_take_s = 1'b1;
      end else begin
        case (buf_fu_t_r)
          2'd0:    s_issue = s_fu_ready;
          2'd1:    m_issue = !hazard_s && m_fu_ready;
          2'd2:    g_issue = !hazard_s && g_fu_ready;
          default: discard_s = 1'b1;
        endcase
      end
    end else begin
      halt_take_s = 1'b0;
    end
    issue_fire_s = s_issue || m_issue || g_issue;

    if (!nRST) begin
      dec_ready = 1'b1;
    end else if (state_r == ST_RUN) begin
      dec_ready = !buf_valid_r || issue_fire_s || discard_s;
    end else begin
      dec_ready = 1'b0;
    end

    if ((m_issue || g_issue) && buf_m_reg_write_r) begin
      set_vec_s = 16'h0001 << buf_rd_r;
    end else begin
      set_vec_s = 16'h0000;
    end
    clr_vec_s = 16'h0000;
    if (m_wb_valid) begin
      clr_vec_s = clr_vec_s | (16'h0001 << m_wb_rd);
    end else begin
      clr_vec_s = clr_vec_s;
    end
    if (g_wb_valid) begin
      clr_vec_s = clr_vec_s | (16'h0001 << g_wb_rd);
    end else begin
      clr_vec_s = clr_vec_s;
    end
    // Set wins over clear; the checker flags the illegal overlap.
    pending_nxt_s = (pending_r & ~clr_vec_s) | set_vec_s;

    iss_matrix_rd = nRST ? buf_rd_r : 4'h0;
    pending       = pending_r;
    halted        = (state_r == ST_HALTED);
  end

  // Instruction buffer, scoreboard and sequencer state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r           <= ST_RUN;
      buf_valid_r       <= 1'b0;
      buf_fu_t_r        <= 2'd0;
      buf_halt_r        <= 1'b0;
      buf_m_reg_write_r <= 1'b0;
      buf_rd_r          <= 4'h0;
      buf_m_src_r       <= 16'h0000;
      pending_r         <= 16'h0000;
    end else begin
      pending_r <= pending_nxt_s;
      if (dec_valid && dec_ready) begin
        buf_valid_r       <= 1'b1;
        buf_fu_t_r        <= dec_fu_t;
        buf_halt_r        <= dec_halt;
        buf_m_reg_write_r <= dec_m_reg_write;
        buf_rd_r          <= dec_matrix_rd;
        buf_m_src_r       <= dec_m_src;
      end else if (issue_fire_s || discard_s || halt_take_s) begin
        buf_valid_r <= 1'b0;
      end else begin
        buf_valid_r <= buf_valid_r;
      end
      // DRAIN looks at the post-writeback scoreboard so halted rises the cycle after the last clear.
      case (state_r)
        ST_RUN:    state_r <= halt_take_s ? ST_DRAIN : ST_RUN;
        ST_DRAIN:  state_r <= (pending_nxt_s == 16'h0000) ? ST_HALTED : ST_DRAIN;
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_RUN;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of RUN cycles where the buffered instruction could not leave.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if ((state_r == ST_RUN) && buf_valid_r && !issue_fire_s && !discard_s &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  dispatch_sequencer_chk u_chk (
    .CLK     (CLK),
    .nRST    (nRST),
    .set_vec (set_vec_s),
    .clr_vec (clr_vec_s)
  );

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Directed bench for dispatch_sequencer: issue latency, RAW/WAW stalls, discard, HALT drain and reset.
module tb_dispatch_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dec_valid;
  logic        dec_ready;
  logic [1:0]  dec_fu_t;
  logic        dec_halt;
  logic        dec_m_reg_write;
  logic [3:0]  dec_matrix_rd;
  logic [15:0] dec_m_src;
  logic        s_fu_ready, m_fu_ready, g_fu_ready;
  logic        s_issue, m_issue, g_issue;
  logic [3:0]  iss_matrix_rd;
  logic        m_wb_valid, g_wb_valid;
  logic [3:0]  m_wb_rd, g_wb_rd;
  logic [15:0] pending;
  logic        halted;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  dispatch_sequencer dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_fu_t        (dec_fu_t),
    .dec_halt        (dec_halt),
    .dec_m_reg_write (dec_m_reg_write),
    .dec_matrix_rd   (dec_matrix_rd),
    .dec_m_src       (dec_m_src),
    .s_fu_ready      (s_fu_ready),
    .m_fu_ready      (m_fu_ready),
    .g_fu_ready      (g_fu_ready),
    .s_issue         (s_issue),
    .m_issue         (m_issue),
    .g_issue         (g_issue),
    .iss_matrix_rd   (iss_matrix_rd),
    .m_wb_valid      (m_wb_valid),
    .m_wb_rd         (m_wb_rd),
    .g_wb_valid      (g_wb_valid),
    .g_wb_rd         (g_wb_rd),
    .pending         (pending),
    .halted          (halted)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] fu, input logic h, input logic w,
                       input logic [3:0] rd, input logic [15:0] src);
    dec_valid       = v;
    dec_fu_t        = fu;
    dec_halt        = h;
    dec_m_reg_write = w;
    dec_matrix_rd   = rd;
    dec_m_src       = src;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 16'h0000);
    s_fu_ready = 1'b1; m_fu_ready = 1'b1; g_fu_ready = 1'b1;
    m_wb_valid = 1'b0; m_wb_rd = 4'h0; g_wb_valid = 1'b0; g_wb_rd = 4'h0;
    #1;
    chk("rst_ready", {31'd0, dec_ready}, 32'd1);
    chk("rst_issue", {29'd0, s_issue, m_issue, g_issue}, 32'd0);
    chk("rst_rd", {28'd0, iss_matrix_rd}, 32'd0);
    tick(); tick();
    nRST = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, dec_ready}, 32'd1);
    chk("post_rst_pending", {16'd0, pending}, 32'h0);
    chk("post_rst_halted", {31'd0, halted}, 32'd0);
    chk("post_rst_issue", {29'd0, s_issue, m_issue, g_issue}, 32'd0);

    // ld.m rd=3: issue the cycle after capture, scoreboard bit the cycle after that
    drive(1'b1, 2'd1, 1'b0, 1'b1, 4'd3, 16'h0000);
    #1;
    chk("ldm_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    dec_valid = 1'b0;
    #1;
    chk("ldm_m_issue", {29'd0, s_issue, m_issue, g_issue}, 32'b010);
    chk("ldm_iss_rd", {28'd0, iss_matrix_rd}, 32'd3);
    chk("ldm_pending_before", {16'd0, pending}, 32'h0);
    tick();
    chk("ldm_pending", {16'd0, pending}, 32'h0008);
    chk("ldm_idle", {29'd0, s_issue, m_issue, g_issue}, 32'd0);

    // gemm reading m3 (rd=7) waits for the m3 writeback, then issues one cycle after the clear
    drive(1'b1, 2'd2, 1'b0, 1'b1, 4'd7, 16'h0008);
    tick();
    dec_valid = 1'b0;
    #1;
    chk("raw_stall0", {31'd0, g_issue}, 32'd0);
    chk("raw_ready0", {31'd0, dec_ready}, 32'd0);
    tick();
    chk("raw_stall1", {31'd0, g_issue}, 32'd0);
    m_wb_valid = 1'b1; m_wb_rd = 4'd3;
    #1;
    chk("raw_stall_wb", {31'd0, g_issue}, 32'd0);
    tick();
    m_wb_valid = 1'b0;
    #1;
    chk("raw_clear", {16'd0, pending}, 32'h0);
    chk("raw_g_issue", {29'd0, s_issue, m_issue, g_issue}, 32'b001);
    chk("raw_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    chk("raw_pending7", {16'd0, pending}, 32'h0080);

    // WAW on m5 with a scalar op queued behind it
    drive(1'b1, 2'd1, 1'b0, 1'b1, 4'd5, 16'h0000);
    tick();
    dec_valid = 1'b0;
    tick();
    chk("waw_setup", {16'd0, pending}, 32'h00A0);
    drive(1'b1, 2'd1, 1'b0, 1'b1, 4'd5, 16'h0000);
    tick();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1;
    chk("waw_stall0", {31'd0, m_issue}, 32'd0);
    chk("waw_ready0", {31'd0, dec_ready}, 32'd0);
    tick();
    chk("waw_stall1", {31'd0, m_issue}, 32'd0);
    chk("waw_ready1", {31'd0, dec_ready}, 32'd0);
    g_wb_valid = 1'b1; g_wb_rd = 4'd5;
    #1;
    chk("waw_stall_wb", {31'd0, m_issue}, 32'd0);
    tick();
    g_wb_valid = 1'b0;
    #1;
    chk("waw_clear", {16'd0, pending}, 32'h0080);
    chk("waw_m_issue", {31'd0, m_issue}, 32'd1);
    chk("waw_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    dec_valid = 1'b0;
    #1;
    chk("scalar_issue", {29'd0, s_issue, m_issue, g_issue}, 32'b100);
    chk("scalar_pending", {16'd0, pending}, 32'h00A0);
    tick();
    chk("scalar_done", {29'd0, s_issue, m_issue, g_issue}, 32'd0);

    // both writeback ports clear their bits in one cycle
    m_wb_valid = 1'b1; m_wb_rd = 4'd7; g_wb_valid = 1'b1; g_wb_rd = 4'd5;
    tick();
    m_wb_valid = 1'b0; g_wb_valid = 1'b0;
    chk("dual_clear", {16'd0, pending}, 32'h0);

    // invalid class is dropped silently
    drive(1'b1, 2'd3, 1'b0, 1'b1, 4'd9, 16'h0000);
    tick();
    dec_valid = 1'b0;
    #1;
    chk("discard_issue", {29'd0, s_issue, m_issue, g_issue}, 32'd0);
    chk("discard_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    chk("discard_pending", {16'd0, pending}, 32'h0);

    // HALT with m4 outstanding: drain, then halted after the m4 writeback
    drive(1'b1, 2'd1, 1'b0, 1'b1, 4'd4, 16'h0000);
    tick();
    dec_valid = 1'b0;
    tick();
    chk("halt_setup", {16'd0, pending}, 32'h0010);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 4'd0, 16'h0000);
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1;
    chk("halt_no_issue", {29'd0, s_issue, m_issue, g_issue}, 32'd0);
    chk("halt_ready", {31'd0, dec_ready}, 32'd0);
    tick();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
    #1;
    chk("drain_ready", {31'd0, dec_ready}, 32'd0);
    chk("drain_halted", {31'd0, halted}, 32'd0);
    g_wb_valid = 1'b1; g_wb_rd = 4'd4;
    tick();
    g_wb_valid = 1'b0;
    dec_valid = 1'b0;
    #1;
    chk("halted_set", {31'd0, halted}, 32'd1);
    chk("halted_pending", {16'd0, pending}, 32'h0);
    chk("halted_ready", {31'd0, dec_ready}, 32'd0);
    tick(); tick();
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halted_issue", {29'd0, s_issue, m_issue, g_issue}, 32'd0);

    // back-to-back ld.m to every register, then reset in the middle of DRAIN
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    chk("rerun_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'd1, 1'b0, 1'b1, 4'(i), 16'h0000);
      tick();
      chk("b2b_issue", {31'd0, m_issue}, 32'd1);
      chk("b2b_rd", {28'd0, iss_matrix_rd}, 32'(i));
    end
    dec_valid = 1'b0;
    tick();
    chk("full_pending", {16'd0, pending}, 32'hFFFF);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 4'd0, 16'h0000);
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    chk("full_drain_ready", {31'd0, dec_ready}, 32'd0);
    chk("full_drain_halted", {31'd0, halted}, 32'd0);
    nRST = 1'b0;
    #1;
    chk("in_rst_ready", {31'd0, dec_ready}, 32'd1);
    tick();
    nRST = 1'b1;
    #1;
    chk("drain_rst_pending", {16'd0, pending}, 32'h0);
    chk("drain_rst_halted", {31'd0, halted}, 32'd0);
    chk("drain_rst_ready", {31'd0, dec_ready}, 32'd1);

`ifdef STALL_CNT_EN
    // 7-cycle RAW stall on m2
    chk("stall_rst", stall_cnt, 32'd0);
    drive(1'b1, 2'd1, 1'b0, 1'b1, 4'd2, 16'h0000);
    tick();
    dec_valid = 1'b0;
    tick();
    chk("stall_setup", {16'd0, pending}, 32'h0004);
    chk("stall_zero", stall_cnt, 32'd0);
    drive(1'b1, 2'd2, 1'b0, 1'b0, 4'd0, 16'h0004);
    tick();
    dec_valid = 1'b0;
    repeat (6) tick();
    m_wb_valid = 1'b1; m_wb_rd = 4'd2;
    tick();
    m_wb_valid = 1'b0;
    #1;
    chk("stall_fire", {31'd0, g_issue}, 32'd1);
    chk("stall_cnt7", stall_cnt, 32'd7);
    tick();
    chk("stall_hold", stall_cnt, 32'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
